// File: rtl/bloco_operativo_if.sv
// Result stream of bloco_operativo: FIFO head data, valid/ready handshake
// and FIFO status flags. The datapath drives it through the master modport
// and the consumer drives it through the slave modport.
interface bloco_operativo_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] result;
  logic             result_valid;
  logic             result_ready;
  logic             fifo_full;
  logic             overflow;

  modport master (
    output result,
    output result_valid,
    output fifo_full,
    output overflow,
    input  result_ready
  );

  modport slave (
    input  result,
    input  result_valid,
    input  fifo_full,
    input  overflow,
    output result_ready
  );
endinterface

// File: rtl/bloco_operativo.sv
// bloco_operativo: datapath stage driven by the control FSM.
// Working registers RX, RH, RS share one ALU; each rising edge of done pushes
// the registered RS into a 2-entry result FIFO drained by valid/ready.
// Optional macro BLOCO_OPERATIVO_SAT_EN: unsigned saturating add/sub/mul
// instead of modular wrap.
module bloco_operativo #(
  parameter int WIDTH      = 8,
  parameter int FIFO_DEPTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] x_in,
  input  logic [WIDTH-1:0] coef_a,
  input  logic [WIDTH-1:0] coef_b,
  input  logic [1:0]       m0,
  input  logic [1:0]       m1,
  input  logic [1:0]       m2,
  input  logic             h,
  input  logic             lx,
  input  logic             lh,
  input  logic             ls,
  input  logic             done,
  output logic [WIDTH-1:0] alu_out,
  bloco_operativo_if.master rbus
);

  // The FIFO logic below is written for exactly two entries.
  localparam logic [1:0] FULL_COUNT = 2'(FIFO_DEPTH);

  logic [WIDTH-1:0]   rx_r;
  logic [WIDTH-1:0]   rh_r;
  logic [WIDTH-1:0]   rs_r;
  logic               done_q_r;
  logic [WIDTH-1:0]   mem_r [0:1];
  logic               wr_ptr_r;
  logic               rd_ptr_r;
  logic [1:0]         count_r;
  logic               overflow_r;

  logic [WIDTH-1:0]   coef_s;
  logic [WIDTH-1:0]   opa_s;
  logic [WIDTH-1:0]   opb_s;
  logic [2*WIDTH-1:0] prod_full_s;
  logic [WIDTH:0]     sum_full_s;
  logic [WIDTH:0]     diff_full_s;
  logic [WIDTH-1:0]   alu_s;
  logic               push_s;
  logic               pop_s;
  logic               push_ok_s;
  logic               drop_s;

  assign coef_s = h ? coef_a : coef_b;

  // Operand A multiplexer (m0).
  always_comb begin
    opa_s = {WIDTH{1'b0}};
    case (m0)
      2'd0:    opa_s = rx_r;
      2'd1:    opa_s = rh_r;
      2'd2:    opa_s = rs_r;
      2'd3:    opa_s = coef_s;
      default: opa_s = {WIDTH{1'b0}};
    endcase
  end

  // Operand B multiplexer (m1).
  always_comb begin
    opb_s = {WIDTH{1'b0}};
    case (m1)
      2'd0:    opb_s = rs_r;
      2'd1:    opb_s = x_in;
      2'd2:    opb_s = rh_r;
      2'd3:    opb_s = rx_r;
      default: opb_s = {WIDTH{1'b0}};
    endcase
  end

  // Full-precision arithmetic; carry/borrow and upper product bits feed saturation.
  assign prod_full_s = {{WIDTH{1'b0}}, opa_s} * {{WIDTH{1'b0}}, opb_s};
  assign sum_full_s  = {1'b0, opa_s} + {1'b0, opb_s};
  assign diff_full_s = {1'b0, opa_s} - {1'b0, opb_s};

`ifdef BLOCO_OPERATIVO_SAT_EN
  // ALU operation select with unsigned saturation.
  always_comb begin
    alu_s = opa_s;
    case (m2)
      2'd0:    alu_s = opa_s;
      2'd1:    alu_s = (|prod_full_s[2*WIDTH-1:WIDTH]) ? {WIDTH{1'b1}} : prod_full_s[WIDTH-1:0];
      2'd2:    alu_s = sum_full_s[WIDTH] ? {WIDTH{1'b1}} : sum_full_s[WIDTH-1:0];
      2'd3:    alu_s = diff_full_s[WIDTH] ? {WIDTH{1'b0}} : diff_full_s[WIDTH-1:0];
      default: alu_s = opa_s;
    endcase
  end
`else
  // Overflow information is discarded in the wrapping build.
  logic unused_ovf_bits_s;
  assign unused_ovf_bits_s = ^{prod_full_s[2*WIDTH-1:WIDTH], sum_full_s[WIDTH], diff_full_s[WIDTH]};

  // ALU operation select with modular wrap to WIDTH bits.
  always_comb begin
    alu_s = opa_s;
    case (m2)
      2'd0:    alu_s = opa_s;
      2'd1:    alu_s = prod_full_s[WIDTH-1:0];
      2'd2:    alu_s = sum_full_s[WIDTH-1:0];
      2'd3:    alu_s = diff_full_s[WIDTH-1:0];
      default: alu_s = opa_s;
    endcase
  end
`endif

  assign alu_out = alu_s;

  // FIFO control: push on done rising edge; a pop frees a slot in the same cycle.
  assign push_s    = done & ~done_q_r;
  assign pop_s     = (count_r != 2'd0) & rbus.result_ready;
  assign push_ok_s = push_s & ((count_r != FULL_COUNT) | pop_s);
  assign drop_s    = push_s & ~push_ok_s;

  // Working registers RX, RH, RS; lh and ls both take the same ALU value.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rx_r <= {WIDTH{1'b0}};
      rh_r <= {WIDTH{1'b0}};
      rs_r <= {WIDTH{1'b0}};
    end else begin
      if (lx) rx_r <= x_in;
      else    rx_r <= rx_r;
      if (lh) rh_r <= alu_s;
      else    rh_r <= rh_r;
      if (ls) rs_r <= alu_s;
      else    rs_r <= rs_r;
    end
  end

  // done edge detector, result FIFO storage/pointers/count and sticky overflow.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q_r   <= 1'b0;
      mem_r[0]   <= {WIDTH{1'b0}};
      mem_r[1]   <= {WIDTH{1'b0}};
      wr_ptr_r   <= 1'b0;
      rd_ptr_r   <= 1'b0;
      count_r    <= 2'd0;
      overflow_r <= 1'b0;
    end else begin
      done_q_r <= done;
      if (push_ok_s) begin
        mem_r[wr_ptr_r] <= rs_r;
        wr_ptr_r        <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      case ({push_ok_s, pop_s})
        2'b10:   count_r <= count_r + 2'd1;
        2'b01:   count_r <= count_r - 2'd1;
        default: count_r <= count_r;
      endcase
      if (drop_s) overflow_r <= 1'b1;
      else        overflow_r <= overflow_r;
    end
  end

  assign rbus.result       = mem_r[rd_ptr_r];
  assign rbus.result_valid = (count_r != 2'd0);
  assign rbus.fifo_full    = (count_r == FULL_COUNT);
  assign rbus.overflow     = overflow_r;

endmodule
